// File: rtl/rf_d16_ctrl.sv
// -----------------------------------------------------------------------------
// rf_d16_ctrl
//
// Access controller for a 512-entry register file shared by 16 hardware
// threads of 32 registers each. Every RF address is {thread[3:0], reg[4:0]}.
//
// Three agents share the RF:
//   - core writeback  : never stalled, always owns the write port when active
//   - debug port      : single-outstanding req/ack access, reads or writes
//   - bank clear      : walks one thread bank writing CLR_VAL to all 32 regs,
//                       stepping only in cycles the write port is free
//
// Ports
//   clka                 single clock for all logic and both RF ports
//   rstn                 synchronous active-low reset
//   wb_we/thread/reg/data  core writeback
//   rd_en/thread/reg     core read request (data on rf_doutb one cycle later)
//   dbg_req/we/addr/wdata  debug request, held until dbg_ack
//   dbg_ack              one-cycle completion pulse
//   dbg_rdata            last captured debug read data
//   clr_start/thread     start a bank clear (ignored while clr_busy)
//   clr_busy             clear in progress
//   clr_done             one-cycle pulse after the final clear write
//   rf_wea/addra/dina    RF write port
//   rf_addrb/rf_doutb    RF read port (synchronous read in the RF macro)
// -----------------------------------------------------------------------------
module rf_d16_ctrl #(
  parameter int              DW      = 32,
  parameter logic [DW-1:0]   CLR_VAL = {DW{1'b0}}
) (
  input  logic          clka,
  input  logic          rstn,
  // core writeback
  input  logic          wb_we,
  input  logic [3:0]    wb_thread,
  input  logic [4:0]    wb_reg,
  input  logic [DW-1:0] wb_data,
  // core read
  input  logic          rd_en,
  input  logic [3:0]    rd_thread,
  input  logic [4:0]    rd_reg,
  // debug access
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [8:0]    dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  // bank clear
  input  logic          clr_start,
  input  logic [3:0]    clr_thread,
  output logic          clr_busy,
  output logic          clr_done,
  // register file
  output logic          rf_wea,
  output logic [8:0]    rf_addra,
  output logic [DW-1:0] rf_dina,
  output logic [8:0]    rf_addrb,
  input  logic [DW-1:0] rf_doutb
);

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_RD   = 2'd1,
    D_ACK  = 2'd2
  } dstate_t;

  typedef enum logic {
    C_IDLE = 1'b0,
    C_RUN  = 1'b1
  } cstate_t;

  // debug FSM
  dstate_t       dstate_r;
  dstate_t       dstate_nxt_s;
  logic          dbg_wr_s;
  logic          dbg_cap_s;
  logic          dbg_ack_r;
  logic [DW-1:0] dbg_rdata_r;

  // clear FSM
  cstate_t       cstate_r;
  cstate_t       cstate_nxt_s;
  logic [4:0]    clr_idx_r;
  logic [4:0]    clr_idx_nxt_s;
  logic [3:0]    clr_thr_r;
  logic          clr_step_s;
  logic          clr_last_s;
  logic          clr_busy_r;
  logic          clr_done_r;

  // write port
  logic          wr_en_s;
  logic [8:0]    wr_addr_s;
  logic [DW-1:0] wr_data_s;
  logic [8:0]    last_addr_r;
  logic [DW-1:0] last_data_r;

  // ---------------------------------------------------------------------------
  // Debug FSM
  // ---------------------------------------------------------------------------

  // Debug state register.
  always_ff @(posedge clka) begin
    if (!rstn) begin
      dstate_r <= D_IDLE;
    end else begin
      dstate_r <= dstate_nxt_s;
    end
  end

  // Debug next-state: a blocked request simply waits in D_IDLE with no timeout.
  always_comb begin
    dstate_nxt_s = dstate_r;
    case (dstate_r)
      D_IDLE: begin
        if (dbg_req && dbg_we && !wb_we) begin
          dstate_nxt_s = D_ACK;
        end else if (dbg_req && !dbg_we && !rd_en) begin
          dstate_nxt_s = D_RD;
        end else begin
          dstate_nxt_s = D_IDLE;
        end
      end
      D_RD:    dstate_nxt_s = D_ACK;
      D_ACK:   dstate_nxt_s = D_IDLE;
      default: dstate_nxt_s = D_IDLE;
    endcase
  end

  // Debug outputs: the write is issued in the same cycle it is accepted; the
  // read captures the RF data that was addressed in the previous cycle.
  always_comb begin
    dbg_wr_s  = 1'b0;
    dbg_cap_s = 1'b0;
    case (dstate_r)
      D_IDLE: begin
        if (rstn && dbg_req && dbg_we && !wb_we) begin
          dbg_wr_s = 1'b1;
        end else begin
          dbg_wr_s = 1'b0;
        end
      end
      D_RD:    dbg_cap_s = 1'b1;
      D_ACK:   dbg_cap_s = 1'b0;
      default: dbg_cap_s = 1'b0;
    endcase
  end

  // Debug registered outputs: ack mirrors entry into D_ACK; rdata only moves on
  // a read capture so debug writes leave it untouched.
  always_ff @(posedge clka) begin
    if (!rstn) begin
      dbg_ack_r   <= 1'b0;
      dbg_rdata_r <= {DW{1'b0}};
    end else begin
      dbg_ack_r <= (dstate_nxt_s == D_ACK);
      if (dbg_cap_s) begin
        dbg_rdata_r <= rf_doutb;
      end else begin
        dbg_rdata_r <= dbg_rdata_r;
      end
    end
  end

  assign dbg_ack   = dbg_ack_r;
  assign dbg_rdata = dbg_rdata_r;

  // ---------------------------------------------------------------------------
  // Clear FSM
  // ---------------------------------------------------------------------------

  // A clear step only happens when neither writeback nor a debug write holds
  // the write port; otherwise the same index is retried next cycle.
  assign clr_step_s = rstn && (cstate_r == C_RUN) && !wb_we && !dbg_wr_s;
  assign clr_last_s = clr_step_s && (clr_idx_r == 5'd31);

  // Clear state, index and latched thread registers.
  always_ff @(posedge clka) begin
    if (!rstn) begin
      cstate_r  <= C_IDLE;
      clr_idx_r <= 5'd0;
      clr_thr_r <= 4'd0;
    end else begin
      cstate_r  <= cstate_nxt_s;
      clr_idx_r <= clr_idx_nxt_s;
      if ((cstate_r == C_IDLE) && clr_start) begin
        clr_thr_r <= clr_thread;
      end else begin
        clr_thr_r <= clr_thr_r;
      end
    end
  end

  // Clear next-state and index; clr_start is only looked at in C_IDLE.
  always_comb begin
    cstate_nxt_s  = cstate_r;
    clr_idx_nxt_s = clr_idx_r;
    case (cstate_r)
      C_IDLE: begin
        if (clr_start) begin
          cstate_nxt_s  = C_RUN;
          clr_idx_nxt_s = 5'd0;
        end else begin
          cstate_nxt_s  = C_IDLE;
          clr_idx_nxt_s = clr_idx_r;
        end
      end
      C_RUN: begin
        if (clr_last_s) begin
          cstate_nxt_s  = C_IDLE;
          clr_idx_nxt_s = 5'd0;
        end else if (clr_step_s) begin
          cstate_nxt_s  = C_RUN;
          clr_idx_nxt_s = clr_idx_r + 5'd1;
        end else begin
          cstate_nxt_s  = C_RUN;
          clr_idx_nxt_s = clr_idx_r;
        end
      end
      default: begin
        cstate_nxt_s  = C_IDLE;
        clr_idx_nxt_s = 5'd0;
      end
    endcase
  end

  // Clear status outputs: busy follows C_RUN, done pulses after the final step.
  always_ff @(posedge clka) begin
    if (!rstn) begin
      clr_busy_r <= 1'b0;
      clr_done_r <= 1'b0;
    end else begin
      clr_busy_r <= (cstate_nxt_s == C_RUN);
      clr_done_r <= clr_last_s;
    end
  end

  assign clr_busy = clr_busy_r;
  assign clr_done = clr_done_r;

  // ---------------------------------------------------------------------------
  // RF ports
  // ---------------------------------------------------------------------------

  // Write port mux with fixed priority writeback > debug > clear. With no
  // writer the address/data hold their last issued values.
  always_comb begin
    wr_addr_s = last_addr_r;
    wr_data_s = last_data_r;
    if (wb_we) begin
      wr_addr_s = {wb_thread, wb_reg};
      wr_data_s = wb_data;
    end else if (dbg_wr_s) begin
      wr_addr_s = dbg_addr;
      wr_data_s = dbg_wdata;
    end else if (clr_step_s) begin
      wr_addr_s = {clr_thr_r, clr_idx_r};
      wr_data_s = CLR_VAL;
    end else begin
      wr_addr_s = last_addr_r;
      wr_data_s = last_data_r;
    end
  end

  // Reset gates the enable so a writeback presented during reset is dropped.
  assign wr_en_s = rstn && (wb_we || dbg_wr_s || clr_step_s);

  // Remember the last issued write so idle cycles keep the port quiet.
  always_ff @(posedge clka) begin
    if (!rstn) begin
      last_addr_r <= 9'd0;
      last_data_r <= {DW{1'b0}};
    end else if (wr_en_s) begin
      last_addr_r <= wr_addr_s;
      last_data_r <= wr_data_s;
    end else begin
      last_addr_r <= last_addr_r;
      last_data_r <= last_data_r;
    end
  end

  assign rf_wea   = wr_en_s;
  assign rf_addra = wr_addr_s;
  assign rf_dina  = wr_data_s;

  // Core reads always win the read port; debug reads wait for a free cycle.
  assign rf_addrb = rd_en ? {rd_thread, rd_reg} : dbg_addr;

endmodule

// File: tb/tb_rf_d16_ctrl.sv
module tb_rf_d16_ctrl;

  localparam int            DW      = 32;
  localparam logic [DW-1:0] CLR_VAL = 32'hC1EA_C1EA;

  logic          clka;
  logic          rstn;
  logic          wb_we;
  logic [3:0]    wb_thread;
  logic [4:0]    wb_reg;
  logic [DW-1:0] wb_data;
  logic          rd_en;
  logic [3:0]    rd_thread;
  logic [4:0]    rd_reg;
  logic          dbg_req;
  logic          dbg_we;
  logic [8:0]    dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;
  logic          clr_start;
  logic [3:0]    clr_thread;
  logic          clr_busy;
  logic          clr_done;
  logic          rf_wea;
  logic [8:0]    rf_addra;
  logic [DW-1:0] rf_dina;
  logic [8:0]    rf_addrb;
  logic [DW-1:0] rf_doutb;

  rf_d16_ctrl #(.DW(DW), .CLR_VAL(CLR_VAL)) dut (
    .clka      (clka),
    .rstn      (rstn),
    .wb_we     (wb_we),
    .wb_thread (wb_thread),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .rd_en     (rd_en),
    .rd_thread (rd_thread),
    .rd_reg    (rd_reg),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata),
    .clr_start (clr_start),
    .clr_thread(clr_thread),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .rf_wea    (rf_wea),
    .rf_addra  (rf_addra),
    .rf_dina   (rf_dina),
    .rf_addrb  (rf_addrb),
    .rf_doutb  (rf_doutb)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  // Behavioural RF: synchronous write, registered read.
  logic [DW-1:0] rf_mem [0:511];
  always @(posedge clka) begin
    if (rf_wea) rf_mem[rf_addra] <= rf_dina;
    rf_doutb <= rf_mem[rf_addrb];
  end

  typedef struct packed {
    logic [8:0]    addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_wr_q[$];
  logic [DW-1:0] exp_ack_q[$];
  wr_t           mon_e;
  logic [DW-1:0] mon_d;
  int            n_tests = 0;
  int            n_fail  = 0;
  int            done_cnt = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_wr(input logic [8:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_wr_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clka);
    #1;
  endtask

  task automatic smp();
    @(negedge clka);
  endtask

  // Scoreboard monitor: every RF write and every debug ack must match the
  // oldest pending expectation.
  always @(negedge clka) begin
    if (rf_wea) begin
      if (exp_wr_q.size() == 0) begin
        check_val("wr_unexpected", 64'(rf_wea), 64'd0);
      end else begin
        mon_e = exp_wr_q.pop_front();
        check_val("wr_addr", 64'(rf_addra), 64'(mon_e.addr));
        check_val("wr_data", 64'(rf_dina), 64'(mon_e.data));
      end
    end
    if (dbg_ack) begin
      if (exp_ack_q.size() == 0) begin
        check_val("ack_unexpected", 64'(dbg_ack), 64'd0);
      end else begin
        mon_d = exp_ack_q.pop_front();
        check_val("ack_rdata", 64'(dbg_rdata), 64'(mon_d));
      end
    end
    if (clr_done) done_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int stolen;
    int busy_cnt;
    int c;

    rstn = 1'b0; wb_we = 1'b1; wb_thread = 4'd1; wb_reg = 5'd1; wb_data = 32'h1111_1111;
    rd_en = 1'b0; rd_thread = 4'd0; rd_reg = 5'd0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 9'd0; dbg_wdata = 32'd0;
    clr_start = 1'b0; clr_thread = 4'd0;

    // Reset, with a writeback that must be suppressed.
    step(); step();
    smp();
    check_val("rst_wea",   64'(rf_wea),    64'd0);
    check_val("rst_ack",   64'(dbg_ack),   64'd0);
    check_val("rst_rdata", 64'(dbg_rdata), 64'd0);
    check_val("rst_busy",  64'(clr_busy),  64'd0);
    check_val("rst_done",  64'(clr_done),  64'd0);
    step();
    rstn = 1'b1; wb_we = 1'b0;

    // Writeback then core read of the same register.
    wb_we = 1'b1; wb_thread = 4'd3; wb_reg = 5'd7; wb_data = 32'hDEAD_BEEF;
    push_wr(9'h067, 32'hDEAD_BEEF);
    smp(); check_val("t1_addra", 64'(rf_addra), 64'h067);
    step();
    wb_we = 1'b0; rd_en = 1'b1; rd_thread = 4'd3; rd_reg = 5'd7;
    smp();
    check_val("t1_idle_wea",  64'(rf_wea),   64'd0);
    check_val("t1_hold_addr", 64'(rf_addra), 64'h067);
    check_val("t1_addrb",     64'(rf_addrb), 64'h067);
    step();
    rd_en = 1'b0;
    smp(); check_val("t1_doutb", 64'(rf_doutb), 64'hDEAD_BEEF);
    step();

    // Debug write blocked by three writeback cycles.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h1FF; dbg_wdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      wb_we = 1'b1; wb_thread = 4'd1; wb_reg = 5'(i); wb_data = 32'h1000_0000 + i;
      push_wr({4'd1, 5'(i)}, 32'h1000_0000 + i);
      smp(); check_val("t2_ack_blocked", 64'(dbg_ack), 64'd0);
      step();
    end
    wb_we = 1'b0;
    push_wr(9'h1FF, 32'h1234_5678);
    exp_ack_q.push_back(32'd0);
    smp();
    check_val("t2_wea_c4", 64'(rf_wea),  64'd1);
    check_val("t2_ack_c4", 64'(dbg_ack), 64'd0);
    step();
    smp(); check_val("t2_ack_c5", 64'(dbg_ack), 64'd1);
    step();
    dbg_req = 1'b0;
    smp(); check_val("t2_ack_c6", 64'(dbg_ack), 64'd0);
    step();

    // Debug read blocked by two core-read cycles.
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h067;
    rd_en = 1'b1; rd_thread = 4'd2; rd_reg = 5'd0;
    for (int i = 0; i < 2; i++) begin
      smp();
      check_val("t3_addrb_core", 64'(rf_addrb), 64'h040);
      check_val("t3_ack_blocked", 64'(dbg_ack), 64'd0);
      step();
    end
    rd_en = 1'b0;
    smp();
    check_val("t3_addrb_dbg", 64'(rf_addrb), 64'h067);
    check_val("t3_ack_c3",    64'(dbg_ack),  64'd0);
    step();
    exp_ack_q.push_back(32'hDEAD_BEEF);
    smp(); check_val("t3_ack_c4", 64'(dbg_ack), 64'd0);
    step();
    smp();
    check_val("t3_ack_c5",   64'(dbg_ack),   64'd1);
    check_val("t3_rdata_c5", 64'(dbg_rdata), 64'hDEAD_BEEF);
    step();
    dbg_req = 1'b0;

    // Unblocked debug write leaves dbg_rdata unchanged.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h155; dbg_wdata = 32'hCAFE_0001;
    push_wr(9'h155, 32'hCAFE_0001);
    exp_ack_q.push_back(32'hDEAD_BEEF);
    smp(); step();
    smp(); check_val("t3w_ack", 64'(dbg_ack), 64'd1);
    step();
    dbg_req = 1'b0;
    smp(); step();

    // Clear thread 5 with no traffic; a second start mid-clear is ignored.
    clr_start = 1'b1; clr_thread = 4'd5;
    for (int i = 0; i < 32; i++) push_wr({4'd5, 5'(i)}, CLR_VAL);
    smp(); check_val("t4_busy_pre", 64'(clr_busy), 64'd0);
    step();
    clr_start = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 4) begin
        clr_start = 1'b1; clr_thread = 4'd9;
      end else begin
        clr_start = 1'b0;
      end
      smp();
      if (clr_busy) busy_cnt++;
      if (clr_done) check_val("t4_done_cycle", 64'(k), 64'd32);
      step();
    end
    clr_start = 1'b0;
    check_val("t4_busy_cycles", 64'(busy_cnt), 64'd32);
    check_val("t4_wr_drained",  64'(exp_wr_q.size()), 64'd0);

    // Clear thread 5 with a writeback stealing every 4th cycle, aimed at the
    // very register the clear is about to write.
    clr_start = 1'b1; clr_thread = 4'd5;
    smp(); step();
    clr_start = 1'b0;
    idx = 0; stolen = 0; busy_cnt = 0; c = 0;
    while (idx < 32 && c < 100) begin
      if ((c % 4) == 3) begin
        wb_we = 1'b1; wb_thread = 4'd5; wb_reg = 5'(idx); wb_data = 32'hBAD0_0000 + c;
        push_wr({4'd5, 5'(idx)}, 32'hBAD0_0000 + c);
        stolen++;
      end else begin
        wb_we = 1'b0;
        push_wr({4'd5, 5'(idx)}, CLR_VAL);
        idx++;
      end
      smp();
      if (clr_busy) busy_cnt++;
      step();
      c++;
    end
    wb_we = 1'b0;
    smp();
    check_val("t5_done", 64'(clr_done), 64'd1);
    check_val("t5_busy_end", 64'(clr_busy), 64'd0);
    check_val("t5_busy_cycles", 64'(busy_cnt), 64'(32 + stolen));
    step();
    for (int r = 0; r <= 32; r++) begin
      rd_en = (r < 32); rd_thread = 4'd5; rd_reg = 5'(r);
      smp();
      if (r > 0) check_val("t5_readback", 64'(rf_doutb), 64'(CLR_VAL));
      step();
    end
    rd_en = 1'b0;

    // Reset mid-clear (index 10 pending) and mid debug read.
    clr_start = 1'b1; clr_thread = 4'd6;
    smp(); step();
    clr_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push_wr({4'd6, 5'(i)}, CLR_VAL);
      if (i == 9) begin
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h010;
      end
      smp(); check_val("t6_busy_run", 64'(clr_busy), 64'd1);
      step();
    end
    rstn = 1'b0; wb_we = 1'b1; wb_thread = 4'd7; wb_reg = 5'd3; wb_data = 32'h7777_0003;
    smp(); check_val("t6_wea_in_rst", 64'(rf_wea), 64'd0);
    step();
    rstn = 1'b1; wb_we = 1'b0; dbg_req = 1'b0;
    smp();
    check_val("t6_busy",  64'(clr_busy),  64'd0);
    check_val("t6_done",  64'(clr_done),  64'd0);
    check_val("t6_ack",   64'(dbg_ack),   64'd0);
    check_val("t6_rdata", 64'(dbg_rdata), 64'd0);
    check_val("t6_wea",   64'(rf_wea),    64'd0);
    step();
    smp();
    check_val("t6_done2", 64'(clr_done), 64'd0);
    check_val("t6_ack2",  64'(dbg_ack),  64'd0);
    step();

    check_val("end_wr_q",  64'(exp_wr_q.size()),  64'd0);
    check_val("end_ack_q", 64'(exp_ack_q.size()), 64'd0);
    check_val("end_done",  64'(done_cnt),         64'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_d16_ctrl.md
RF_D16_CTRL -- requirements
Module: rf_d16_ctrl

Interface
REQ-001 SHALL have parameter DW, default 32, meaning register data width.
REQ-002 SHALL have parameter CLR_VAL, default 0, meaning value written by the bank-clear engine.
REQ-003 SHALL have port clka  input  1  single clock for all logic and both RF ports.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low, sampled on clka.
REQ-005 SHALL have ports wb_we input 1, wb_thread input 4, wb_reg input 5, wb_data input DW, meaning core writeback (never stalled).
REQ-006 SHALL have ports rd_en input 1, rd_thread input 4, rd_reg input 5, meaning core read request.
REQ-007 SHALL have ports dbg_req input 1, dbg_we input 1, dbg_addr input 9, dbg_wdata input DW, dbg_ack output 1, dbg_rdata output DW, meaning debug access handshake.
REQ-008 SHALL have ports clr_start input 1, clr_thread input 4, clr_busy output 1, clr_done output 1, meaning thread bank clear.
REQ-009 SHALL have ports rf_wea output 1, rf_addra output 9, rf_dina output DW, rf_addrb output 9, rf_doutb input DW, meaning RF connections.

Function
REQ-010 SHALL form every RF address as {thread[3:0], reg[4:0]}; 16 threads x 32 registers = 512 entries.
REQ-011 SHALL drive the write port combinationally with fixed priority: wb_we > eligible debug write > clear step.
REQ-012 SHALL drive rf_addrb combinationally: rd_en ? {rd_thread,rd_reg} : dbg_addr; core read data appears on rf_doutb one cycle later, unmodified.
REQ-013 SHALL implement debug FSM D_IDLE, D_RD, D_ACK.
REQ-014 SHALL, in D_IDLE with dbg_req=1, dbg_we=1 and wb_we=0, issue the debug write that cycle and go to D_ACK.
REQ-015 SHALL, in D_IDLE with dbg_req=1, dbg_we=0 and rd_en=0, present dbg_addr on rf_addrb that cycle and go to D_RD.
REQ-016 SHALL, in D_RD, capture rf_doutb into dbg_rdata and go to D_ACK.
REQ-017 SHALL, in D_ACK, assert dbg_ack for exactly one cycle and return to D_IDLE; dbg_req SHALL be held by the requester until dbg_ack.
REQ-018 SHALL keep the debug request pending (no state change) while blocked by wb_we (write) or rd_en (read); no timeout.
REQ-019 SHALL hold dbg_rdata stable from capture until the next debug read capture; debug writes leave it unchanged.
REQ-020 SHALL implement clear FSM C_IDLE, C_RUN with a 5-bit index counter.
REQ-021 SHALL, on clr_start in C_IDLE, latch clr_thread, zero the index, enter C_RUN and assert clr_busy from the next cycle.
REQ-022 SHALL, in C_RUN, write CLR_VAL to {latched thread, index} in each cycle the write port is not taken by wb or debug, then increment the index.
REQ-023 SHALL, after the step writing index 31, return to C_IDLE, deassert clr_busy and pulse clr_done for one cycle (the cycle after that write).
REQ-024 SHALL ignore clr_start while clr_busy=1.
REQ-025 SHALL resolve same-address conflicts by issue order only: a later clear step overwrites an earlier wb write; a wb write in the same cycle wins and the clear step retries next cycle.
REQ-026 SHALL drive rf_wea=0 when no source writes; rf_addra/rf_dina then hold their last values.

Reset
REQ-027 SHALL, while rstn=0 at a clka edge, force D_IDLE and C_IDLE; dbg_ack=0, dbg_rdata=0, clr_busy=0, clr_done=0, index=0, latched thread=0.
REQ-028 SHALL drive rf_wea=0 during reset regardless of wb_we; an in-progress clear or debug access is abandoned with no ack and no done.

Verification
REQ-029 SHALL be covered: wb_we=1, thread 3, reg 7, data 0xDEADBEEF; next cycle rd_en thread 3 reg 7 -> rf_addra=0x067, rf_doutb=0xDEADBEEF one cycle later.
REQ-030 SHALL be covered: debug write addr 0x1FF, data 0x12345678, with wb_we=1 for 3 cycles -> write issues in cycle 4, dbg_ack in cycle 5.
REQ-031 SHALL be covered: debug read addr 0x067 with rd_en=1 for 2 cycles -> dbg_ack 2 cycles after rd_en drops, dbg_rdata=0xDEADBEEF.
REQ-032 SHALL be covered: clr_start thread 5 with no other traffic -> rf_wea on 0x0A0..0x0BF for 32 consecutive cycles, clr_done once, clr_busy high 32 cycles.
REQ-033 SHALL be covered: clear thread 5 with wb_we on every 4th cycle -> clear completes in 32 + stolen cycles, all 32 entries = CLR_VAL afterward.
REQ-034 SHALL be covered: rstn=0 mid-clear at index 10 and mid debug read -> clr_busy=0, no clr_done, no dbg_ack, rf_wea=0 next cycle.
